// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port (core c / DMA d) sequencer in front of a single-port
// synchronous dmem with 1-cycle read latency. Adds byte/half stores via
// read-modify-write, lane-extracts loads, and rejects misaligned requests.
// Optional feature macro: DMEM_CTRL_RR_EN (round-robin arbitration when
// defined; fixed priority c over d otherwise).
module dmem_ctrl #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c_req_valid,
  output logic                     c_req_ready,
  input  logic                     c_req_we,
  input  logic [31:0]              c_req_addr,
  input  logic [1:0]               c_req_size,
  input  logic [31:0]              c_req_wdata,
  output logic                     c_resp_valid,
  output logic                     c_resp_err,
  output logic [31:0]              c_resp_rdata,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic                     d_req_we,
  input  logic [31:0]              d_req_addr,
  input  logic [1:0]               d_req_size,
  input  logic [31:0]              d_req_wdata,
  output logic                     d_resp_valid,
  output logic                     d_resp_err,
  output logic [31:0]              d_resp_rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int AB = ADDRESS_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t      state, state_nx;
  logic        sel_c, sel_d, accept;
  logic        owner;
  logic        we_q;
  logic [AB-1:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        misaligned, is_word;
  logic [4:0]  shamt;
  logic [31:0] shifted, load_data, lane_mask, merged;
  logic        resp_v, resp_e;
  logic [31:0] resp_d;

  // Upper address bits beyond the dmem window are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_req_addr[31:AB], d_req_addr[31:AB]};

`ifdef DMEM_CTRL_RR_EN
  logic grant;  // 0 = c has priority, 1 = d has priority

  // Round-robin: the port holding the grant wins a tie; a lone requester always wins.
  always_comb begin
    sel_c = c_req_valid & (~grant | ~d_req_valid);
    sel_d = d_req_valid & ( grant | ~c_req_valid);
  end

  // Grant flips to the other port after every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      grant <= 1'b0;
    else if (accept) grant <= sel_c;
  end
`else
  // Fixed priority: c always beats d.
  always_comb begin
    sel_c = c_req_valid;
    sel_d = d_req_valid & ~c_req_valid;
  end
`endif

  assign accept = (state == IDLE) & (sel_c | sel_d);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request fields are captured only at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner   <= sel_d;
      we_q    <= sel_d ? d_req_we            : c_req_we;
      addr_q  <= sel_d ? d_req_addr[AB-1:0]  : c_req_addr[AB-1:0];
      size_q  <= sel_d ? d_req_size          : c_req_size;
      wdata_q <= sel_d ? d_req_wdata         : c_req_wdata;
    end
  end

  // Alignment check, load lane extraction and store lane merge.
  always_comb begin
    is_word    = size_q[1];
    misaligned = ((size_q == 2'd1) & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
    shamt      = {addr_q[1:0], 3'b000};
    shifted    = mem_rdata >> shamt;
    case (size_q)
      2'd0:    load_data = {24'd0, shifted[7:0]};
      2'd1:    load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    lane_mask = (size_q == 2'd0) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Next-state and memory/response outputs.
  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_wdata = '0;
    resp_v    = 1'b0;
    resp_e    = 1'b0;
    resp_d    = '0;
    case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        if (misaligned) begin
          resp_v   = 1'b1;
          resp_e   = 1'b1;
          state_nx = IDLE;
        end else if (we_q & is_word) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          resp_v    = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: begin
        resp_v = 1'b1;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = merged;
        end else begin
          resp_d = load_data;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Ready only in IDLE toward the winning requester, held low during reset;
  // responses steered to the latched owner.
  always_comb begin
    c_req_ready  = rst_n & (state == IDLE) & sel_c;
    d_req_ready  = rst_n & (state == IDLE) & sel_d;
    c_resp_valid = resp_v & ~owner;
    c_resp_err   = resp_e & ~owner;
    c_resp_rdata = owner ? '0 : resp_d;
    d_resp_valid = resp_v & owner;
    d_resp_err   = resp_e & owner;
    d_resp_rdata = owner ? resp_d : '0;
    mem_addr     = addr_q[AB-1:2];
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural 1-cycle dmem.
module tb_dmem_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req_valid = 1'b0, c_req_ready, c_req_we = 1'b0;
  logic [31:0]   c_req_addr = '0, c_req_wdata = '0, c_resp_rdata;
  logic [1:0]    c_req_size = '0;
  logic          c_resp_valid, c_resp_err;
  logic          d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0;
  logic [31:0]   d_req_addr = '0, d_req_wdata = '0, d_resp_rdata;
  logic [1:0]    d_req_size = '0;
  logic          d_resp_valid, d_resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [31:0]   mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  int          r_lat, r_wecnt;
  logic [31:0] r_rd, r_wd;
  logic        r_err, r_other;

  dmem_ctrl #(.ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_size(c_req_size), .c_req_wdata(c_req_wdata),
    .c_resp_valid(c_resp_valid), .c_resp_err(c_resp_err), .c_resp_rdata(c_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_err(d_resp_err), .d_resp_rdata(d_resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous dmem, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic rdy(input bit p);
    return p ? d_req_ready : c_req_ready;
  endfunction

  task automatic drive(input bit p, input logic v, input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd);
    if (!p) begin
      c_req_valid = v; c_req_we = we; c_req_addr = a; c_req_size = sz; c_req_wdata = wd;
    end else begin
      d_req_valid = v; d_req_we = we; d_req_addr = a; d_req_size = sz; d_req_wdata = wd;
    end
  endtask

  // Issues one request, scrambles the request fields right after acceptance,
  // and records latency, response and write activity until the response.
  task automatic issue(input bit p, input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] wd);
    int n;
    bit got;
    drive(p, 1'b1, we, a, sz, wd);
    n = 0;
    r_lat = 99; r_wecnt = 0; r_rd = '0; r_wd = '0; r_err = 1'b0; r_other = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy(p)) break;
      n++;
      if (n > 20) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout port=%0d addr=%h got=no_ready exp=ready", p, a);
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        return;
      end
    end
    @(posedge clk); #1;
    drive(p, 1'b0, ~we, ~a, ~sz, ~wd);
    got = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_we) begin r_wecnt++; r_wd = mem_wdata; end
      if (p ? c_resp_valid : d_resp_valid) r_other = 1'b1;
      if (p ? d_resp_valid : c_resp_valid) begin
        r_lat = k;
        r_rd  = p ? d_resp_rdata : c_resp_rdata;
        r_err = p ? d_resp_err   : c_resp_err;
        got   = 1'b1;
        break;
      end
    end
    if (!got) r_lat = 99;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    c_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({c_req_ready, d_req_ready, c_resp_valid, c_resp_err, d_resp_valid, d_resp_err, mem_we} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ctl got=%b exp=0000000",
        {c_req_ready, d_req_ready, c_resp_valid, c_resp_err, d_resp_valid, d_resp_err, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, c_resp_rdata, d_resp_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mem_addr, mem_wdata, c_resp_rdata, d_resp_rdata);
    end
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    issue(1'b0, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF);
    n_cmp++; if (r_lat !== 1) begin n_bad++; $display("FAIL wst_lat got=%0d exp=1", r_lat); end
    n_cmp++; if (r_wecnt !== 1) begin n_bad++; $display("FAIL wst_wecnt got=%0d exp=1", r_wecnt); end
    n_cmp++; if (r_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wst_wdata got=%h exp=deadbeef", r_wd); end
    n_cmp++; if ({r_err, r_rd, r_other} !== '0) begin n_bad++; $display("FAIL wst_resp got=%b/%h/%b exp=0/0/0", r_err, r_rd, r_other); end
    issue(1'b0, 1'b0, 32'h100, 2'd2, 32'h0);
    n_cmp++; if (r_lat !== 2) begin n_bad++; $display("FAIL wld_lat got=%0d exp=2", r_lat); end
    n_cmp++; if (r_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wld_rdata got=%h exp=deadbeef", r_rd); end
    n_cmp++; if (r_wecnt !== 0) begin n_bad++; $display("FAIL wld_wecnt got=%0d exp=0", r_wecnt); end
  endtask

  task automatic test_subword();
    issue(1'b0, 1'b1, 32'h101, 2'd0, 32'hFFFFFF55);
    n_cmp++; if (r_lat !== 2) begin n_bad++; $display("FAIL bst_lat got=%0d exp=2", r_lat); end
    n_cmp++; if (r_wecnt !== 1) begin n_bad++; $display("FAIL bst_wecnt got=%0d exp=1", r_wecnt); end
    n_cmp++; if (r_wd !== 32'hDEAD55EF) begin n_bad++; $display("FAIL bst_wdata got=%h exp=dead55ef", r_wd); end
    issue(1'b0, 1'b0, 32'h102, 2'd1, 32'h0);
    n_cmp++; if (r_rd !== 32'h0000DEAD) begin n_bad++; $display("FAIL hld_rdata got=%h exp=0000dead", r_rd); end
    issue(1'b0, 1'b0, 32'h103, 2'd0, 32'h0);
    n_cmp++; if (r_rd !== 32'h000000DE) begin n_bad++; $display("FAIL bld_rdata got=%h exp=000000de", r_rd); end
    issue(1'b1, 1'b1, 32'h102, 2'd1, 32'hABCD1234);
    n_cmp++; if (r_wd !== 32'h123455EF) begin n_bad++; $display("FAIL hst_wdata got=%h exp=123455ef", r_wd); end
    n_cmp++; if (r_other !== 1'b0) begin n_bad++; $display("FAIL hst_other got=%b exp=0", r_other); end
    issue(1'b0, 1'b0, 32'h100, 2'd3, 32'h0);
    n_cmp++; if (r_rd !== 32'h123455EF) begin n_bad++; $display("FAIL size3_rdata got=%h exp=123455ef", r_rd); end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 32'h103, 2'd1, 32'h0);
    n_cmp++; if (r_lat !== 1) begin n_bad++; $display("FAIL mis_h_lat got=%0d exp=1", r_lat); end
    n_cmp++; if ({r_err, r_rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mis_h_resp got=%b/%h exp=1/0", r_err, r_rd); end
    n_cmp++; if ({r_wecnt, r_other} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL mis_h_side got=%0d/%b exp=0/0", r_wecnt, r_other); end
    issue(1'b0, 1'b1, 32'h102, 2'd2, 32'h77777777);
    n_cmp++; if ({r_err, r_lat} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL mis_w_resp got=%b/%0d exp=1/1", r_err, r_lat); end
    n_cmp++; if (r_wecnt !== 0) begin n_bad++; $display("FAIL mis_w_wecnt got=%0d exp=0", r_wecnt); end
    issue(1'b0, 1'b0, 32'h100, 2'd2, 32'h0);
    n_cmp++; if (r_rd !== 32'h123455EF) begin n_bad++; $display("FAIL mis_w_keep got=%h exp=123455ef", r_rd); end
  endtask

  task automatic test_wrap_and_hold();
    issue(1'b0, 1'b1, 32'h400, 2'd2, 32'hCAFEF00D);
    issue(1'b0, 1'b0, 32'h000, 2'd2, 32'h0);
    n_cmp++; if (r_rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap_rdata got=%h exp=cafef00d", r_rd); end
    issue(1'b0, 1'b1, 32'h104, 2'd2, 32'h0BADF00D);
    issue(1'b0, 1'b0, 32'h104, 2'd2, 32'h0);
    n_cmp++; if (r_rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL hold_rdata got=%h exp=0badf00d", r_rd); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(1'b0, 1'b1, 32'h200, 2'd2, 32'h11223344);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 2'd0, 32'h000000AA);
    n = 0;
    do begin @(negedge clk); n++; end while (!c_req_ready && n < 20);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_issue_we got=%b exp=0", mem_we); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rmid_data_we got=%b exp=1", mem_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_we, c_resp_valid, d_resp_valid} !== 3'b000) begin n_bad++; $display("FAIL rmid_drop got=%b exp=000", {mem_we, c_resp_valid, d_resp_valid}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h200, 2'd2, 32'h0);
    n_cmp++; if (r_rd !== 32'h11223344) begin n_bad++; $display("FAIL rmid_keep got=%h exp=11223344", r_rd); end
  endtask

  task automatic test_arbitration();
    int k, cyc, last;
    bit g [4];
    bit d_seen;
    apply_reset();
    k = 0; cyc = 0; last = 0; d_seen = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h100, 2'd2, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 2'd2, '0);
    while (k < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (d_req_ready) d_seen = 1'b1;
      if (c_req_ready || d_req_ready) begin
        g[k] = d_req_ready;
        if (k > 0) begin
          n_cmp++; if (cyc - last !== 3) begin n_bad++; $display("FAIL b2b_gap%0d got=%0d exp=3", k, cyc - last); end
        end
        last = cyc;
        k++;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL arb_count got=%0d exp=4", k); end
`ifdef DMEM_CTRL_RR_EN
    n_cmp++; if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin n_bad++; $display("FAIL arb_rr got=%b exp=0101", {g[0], g[1], g[2], g[3]}); end
`else
    n_cmp++; if ({g[0], g[1], g[2], g[3]} !== 4'b0000) begin n_bad++; $display("FAIL arb_fixed got=%b exp=0000", {g[0], g[1], g[2], g[3]}); end
    n_cmp++; if (d_seen !== 1'b0) begin n_bad++; $display("FAIL arb_d_ready got=%b exp=0", d_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword();
    test_misaligned();
    test_wrap_and_hold();
    test_reset_mid();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
